// File: rtl/rf_pkg.sv
// Shared defaults for the register-file/scoreboard slice.
//   RF_DATA_W / RF_ADDR_W / RF_N_RD : default register width, address width
//                                     and read-port count
//   ZERO_ADDR                       : index of the hardwired-zero register
package rf_pkg;
   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_N_RD   = 2;
   localparam int ZERO_ADDR = 0;
endpackage

// File: rtl/rf_pend.sv
// Pending-write scoreboard: one bit per register plus a population counter.
// Ports:
//   CLK, RST          : clock (rising edge), async active-high reset
//   W, W_reg          : writeback strobe/address, clears the pending bit
//   ISS, ISS_reg      : issue strobe/destination, sets the pending bit
//   pend              : pending vector, bit i = register i has a producer in flight
//   cnt               : number of set bits in pend
import rf_pkg::*;

module rf_pend #(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     W,
   input  logic [ADDR_W-1:0]        W_reg,
   input  logic                     ISS,
   input  logic [ADDR_W-1:0]        ISS_reg,
   output logic [(1<<ADDR_W)-1:0]   pend,
   output logic [ADDR_W:0]          cnt
);
   localparam int DEPTH = 1 << ADDR_W;

   logic             w_ok, iss_ok, rise, fall;
   logic [DEPTH-1:0] pend_nxt;

   always_comb begin
      w_ok     = W   && !(ZERO_REG && (W_reg   == ADDR_W'(ZERO_ADDR)));
      iss_ok   = ISS && !(ZERO_REG && (ISS_reg == ADDR_W'(ZERO_ADDR)));
      // Issue is applied after the clear so the newer producer wins on a
      // same-register collision.
      pend_nxt = pend;
      if (w_ok)   pend_nxt[W_reg]   = 1'b0;
      if (iss_ok) pend_nxt[ISS_reg] = 1'b1;
      rise = iss_ok && !pend[ISS_reg];
      fall = w_ok && pend[W_reg] && !(iss_ok && (ISS_reg == W_reg));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pend <= '0;
         cnt  <= '0;
      end else begin
         pend <= pend_nxt;
         // rise and fall can both occur (different registers): net zero.
         case ({rise, fall})
            2'b10:   cnt <= cnt + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   cnt <= cnt - {{ADDR_W{1'b0}}, 1'b1};
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/rf_scoreboard.sv
// Multi-read-port register file with integrated pending-write scoreboard.
// Ports:
//   CLK, RST          : clock (rising edge), async active-high reset
//   W, W_reg, W_data  : writeback port
//   ISS, ISS_reg      : issue strobe, marks ISS_reg pending
//   R_reg             : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   R_data            : packed read data, port k at [k*DATA_W +: DATA_W]
//   R_busy            : per-port pending flag of the addressed register
//   PEND_cnt          : number of pending registers
import rf_pkg::*;

module rf_scoreboard #(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int N_RD     = RF_N_RD,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     W,
   input  logic [ADDR_W-1:0]        W_reg,
   input  logic [DATA_W-1:0]        W_data,
   input  logic                     ISS,
   input  logic [ADDR_W-1:0]        ISS_reg,
   input  logic [N_RD*ADDR_W-1:0]   R_reg,
   output logic [N_RD*DATA_W-1:0]   R_data,
   output logic [N_RD-1:0]          R_busy,
   output logic [ADDR_W:0]          PEND_cnt
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic              w_ok;

   assign w_ok = W && !(ZERO_REG && (W_reg == ADDR_W'(ZERO_ADDR)));

   rf_pend #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_pend (
      .CLK     (CLK),
      .RST     (RST),
      .W       (W),
      .W_reg   (W_reg),
      .ISS     (ISS),
      .ISS_reg (ISS_reg),
      .pend    (pend),
      .cnt     (PEND_cnt)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (w_ok) begin
         mem[W_reg] <= W_data;
      end
   end

   // Read ports: zeroed r0 first, then same-cycle write bypass, then array.
   // A bypassed read reports not-busy: the value is the producer's result.
   for (genvar k = 0; k < N_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              zero, hit;

      assign addr = R_reg[k*ADDR_W +: ADDR_W];
      assign zero = ZERO_REG && (addr == ADDR_W'(ZERO_ADDR));
      assign hit  = BYPASS && w_ok && (W_reg == addr);

      always_comb begin
         R_data[k*DATA_W +: DATA_W] = mem[addr];
         R_busy[k]                  = pend[addr];
         if (zero) begin
            R_data[k*DATA_W +: DATA_W] = '0;
            R_busy[k]                  = 1'b0;
         end else if (hit) begin
            R_data[k*DATA_W +: DATA_W] = W_data;
            R_busy[k]                  = 1'b0;
         end
      end
   end
endmodule
